// File: rtl/dds_pkg.sv
// Shared register map, sweep enums and configuration payload for the DDS block.
package dds_pkg;

    localparam int unsigned DELTA_W = 32;

    // DDS register-map addresses
    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_THETAS = 1;
    localparam int unsigned ADDR_DELTAS = 2;
    localparam int unsigned ADDR_AMPLS  = 3;
    localparam int unsigned ADDR_CLKDIV = 4;
    localparam int unsigned ADDR_STAT   = 5;
    localparam int unsigned ADDR_LNGTH  = 6;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        LOOP   = 2'd1,
        TRI    = 2'd2
    } sweep_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        DWELL  = 2'd2,
        FINISH = 2'd3
    } sweep_state_e;

    // Sweep configuration captured at start
    typedef struct packed {
        sweep_mode_e          mode;
        logic [DELTA_W-1:0]   start_delta;
        logic [DELTA_W-1:0]   end_delta;
        logic [DELTA_W-1:0]   step_delta;
    } sweep_cfg_t;

    // Map the raw mode field; the unused encoding behaves as a single sweep
    function automatic sweep_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_mode = LOOP;
            2'd2:    decode_mode = TRI;
            default: decode_mode = SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/dds_sweep_step.sv
// Next phase-increment computation with endpoint clamping (33-bit, no wrap).
module dds_sweep_step
    import dds_pkg::*;
(
    input  logic [DELTA_W-1:0] cur,
    input  logic [DELTA_W-1:0] step,
    input  logic [DELTA_W-1:0] start_delta,
    input  logic [DELTA_W-1:0] end_delta,
    input  logic               dir_down,
    output logic [DELTA_W-1:0] next_delta,
    output logic               at_end,
    output logic               at_start
);

    logic [DELTA_W:0] up_sum;
    logic [DELTA_W:0] down_lim;
    logic [DELTA_W-1:0] up_next;
    logic [DELTA_W-1:0] down_next;

    // Clamp to the endpoint whenever the step would reach or cross it
    always_comb begin
        up_sum    = {1'b0, cur} + {1'b0, step};
        down_lim  = {1'b0, start_delta} + {1'b0, step};
        up_next   = (up_sum >= {1'b0, end_delta}) ? end_delta : up_sum[DELTA_W-1:0];
        down_next = ({1'b0, cur} < down_lim) ? start_delta : (cur - step);
        next_delta = dir_down ? down_next : up_next;
        at_end     = (cur == end_delta);
        at_start   = (cur == start_delta);
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Chirp sequencer: second bus master stepping DELTAS; host always wins the bus.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned DWELL_W     = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DELTAS_ADDR = 2
) (
    input  logic               clk,
    input  logic               a_rst_n,
    input  logic               i_host_write,
    input  logic               i_host_read,
    input  logic [31:0]        i_host_addrs,
    input  logic [31:0]        i_host_writedata,
    output logic [31:0]        o_host_readdata,
    output logic               o_bus_write,
    output logic               o_bus_read,
    output logic [31:0]        o_bus_addrs,
    output logic [31:0]        o_bus_writedata,
    input  logic [31:0]        i_bus_readdata,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [1:0]         i_mode,
    input  logic [31:0]        i_start_delta,
    input  logic [31:0]        i_end_delta,
    input  logic [31:0]        i_step_delta,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_pt_cnt,
    output logic               o_stall
);

    sweep_state_e       state_q, state_d;
    sweep_cfg_t         cfg_q, cfg_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DELTA_W-1:0] cur_q, cur_d;
    logic               dir_down_q, dir_down_d;
    logic [CNT_W-1:0]   pt_cnt_q, pt_cnt_d;

    logic               host_req;
    logic               grant;
    logic               degenerate;
    logic               dir_eff;
    logic [DELTA_W-1:0] next_delta;
    logic               at_end;
    logic               at_start;

    assign host_req   = i_host_write | i_host_read;
    assign grant      = (state_q == WRITE) & ~host_req;
    assign degenerate = (cfg_q.step_delta == '0) | (cfg_q.start_delta >= cfg_q.end_delta);

    // Triangle reverses at either endpoint; other modes always step up
    assign dir_eff = (cfg_q.mode == TRI) & (dir_down_q ? ~at_start : at_end);

    dds_sweep_step u_step (
        .cur         (cur_q),
        .step        (cfg_q.step_delta),
        .start_delta (cfg_q.start_delta),
        .end_delta   (cfg_q.end_delta),
        .dir_down    (dir_eff),
        .next_delta  (next_delta),
        .at_end      (at_end),
        .at_start    (at_start)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            cur_q      <= '0;
            dir_down_q <= 1'b0;
            pt_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            dir_down_q <= dir_down_d;
            pt_cnt_q   <= pt_cnt_d;
        end
    end

    // Next-state and datapath update; abort overrides everything
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        dir_down_d = dir_down_q;
        pt_cnt_d   = pt_cnt_q;

        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        cfg_d.mode        = decode_mode(i_mode);
                        cfg_d.start_delta = i_start_delta;
                        cfg_d.end_delta   = i_end_delta;
                        cfg_d.step_delta  = i_step_delta;
                        dwell_d           = i_dwell;
                        cur_d             = i_start_delta;
                        dir_down_d        = 1'b0;
                        pt_cnt_d          = '0;
                        state_d           = WRITE;
                    end
                end
                WRITE: begin
                    if (grant) begin
                        pt_cnt_d = pt_cnt_q + CNT_W'(1);
                        cnt_d    = dwell_q;
                        state_d  = DWELL;
                    end
                end
                DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (degenerate || (cfg_q.mode == SINGLE && at_end)) begin
                        state_d = FINISH;
                    end else if (cfg_q.mode == LOOP && at_end) begin
                        cur_d   = cfg_q.start_delta;
                        state_d = WRITE;
                    end else begin
                        cur_d      = next_delta;
                        dir_down_d = dir_eff;
                        state_d    = WRITE;
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Bus mux: host owns the bus whenever it strobes
    always_comb begin
        o_bus_write     = (state_q == WRITE);
        o_bus_read      = 1'b0;
        o_bus_addrs     = 32'(DELTAS_ADDR);
        o_bus_writedata = cur_q;
        if (host_req) begin
            o_bus_write     = i_host_write;
            o_bus_read      = i_host_read;
            o_bus_addrs     = i_host_addrs;
            o_bus_writedata = i_host_writedata;
        end
    end

    assign o_host_readdata = i_bus_readdata;
    assign o_busy          = (state_q != IDLE);
    assign o_done          = (state_q == FINISH);
    assign o_pt_cnt        = pt_cnt_q;
    assign o_stall         = (state_q == WRITE) & host_req;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for the DDS frequency-sweep sequencer.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        a_rst_n = 1'b0;
    logic        i_host_write = 1'b0;
    logic        i_host_read = 1'b0;
    logic [31:0] i_host_addrs = '0;
    logic [31:0] i_host_writedata = '0;
    logic [31:0] o_host_readdata;
    logic        o_bus_write;
    logic        o_bus_read;
    logic [31:0] o_bus_addrs;
    logic [31:0] o_bus_writedata;
    logic [31:0] i_bus_readdata = '0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [1:0]  i_mode = '0;
    logic [31:0] i_start_delta = '0;
    logic [31:0] i_end_delta = '0;
    logic [31:0] i_step_delta = '0;
    logic [15:0] i_dwell = '0;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_pt_cnt;
    logic        o_stall;

    dds_sweep_ctrl dut (
        .clk              (clk),
        .a_rst_n          (a_rst_n),
        .i_host_write     (i_host_write),
        .i_host_read      (i_host_read),
        .i_host_addrs     (i_host_addrs),
        .i_host_writedata (i_host_writedata),
        .o_host_readdata  (o_host_readdata),
        .o_bus_write      (o_bus_write),
        .o_bus_read       (o_bus_read),
        .o_bus_addrs      (o_bus_addrs),
        .o_bus_writedata  (o_bus_writedata),
        .i_bus_readdata   (i_bus_readdata),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_mode           (i_mode),
        .i_start_delta    (i_start_delta),
        .i_end_delta      (i_end_delta),
        .i_step_delta     (i_step_delta),
        .i_dwell          (i_dwell),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_pt_cnt         (o_pt_cnt),
        .o_stall          (o_stall)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] wr_val[$];
    int          wr_cyc[$];
    int          done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log sweeper-owned DELTAS writes and done pulses
    always @(negedge clk) begin
        if (a_rst_n && o_bus_write && !(i_host_write || i_host_read) && o_bus_addrs == 32'd2) begin
            wr_val.push_back(o_bus_writedata);
            wr_cyc.push_back(cyc);
        end
        if (a_rst_n && o_done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_log();
        wr_val.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    // Pulse start with the given configuration, then scramble inputs
    task automatic start_sweep(input logic [1:0] mode, input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] st, input logic [15:0] dw);
        @(posedge clk); #1;
        i_mode = mode; i_start_delta = s; i_end_delta = e; i_step_delta = st; i_dwell = dw;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_mode = 2'd1; i_start_delta = 32'd999; i_end_delta = 32'd7; i_step_delta = 32'd3; i_dwell = 16'd9;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (!o_busy) break;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (wr_val.size() >= n) break;
        end
        check(tag, 32'(wr_val.size() >= n), 32'd1);
    endtask

    task automatic abort_pulse();
        @(posedge clk); #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
    endtask

    logic [31:0] exp_single[4] = '{32'd100, 32'd110, 32'd120, 32'd130};
    logic [31:0] exp_over[4]   = '{32'd100, 32'd110, 32'd120, 32'd125};
    logic [31:0] exp_tri[7]    = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};

    initial begin
        // Reset state
        #23 a_rst_n = 1'b1;
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_bus_write", 32'(o_bus_write), 32'd0);
        check("rst_pt_cnt", 32'(o_pt_cnt), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("idle_addr", o_bus_addrs, 32'd2);

        // Host read passthrough while idle
        i_host_read = 1'b1; i_host_addrs = 32'd6; i_bus_readdata = 32'h1234;
        #1;
        check("hrd_bus_read", 32'(o_bus_read), 32'd1);
        check("hrd_addr", o_bus_addrs, 32'd6);
        check("hrd_data", o_host_readdata, 32'h1234);
        i_host_read = 1'b0; i_host_addrs = '0;

        // SINGLE 100..130 step 10 dwell 3
        clear_log();
        start_sweep(2'd0, 32'd100, 32'd130, 32'd10, 16'd3);
        check("s1_first_write", 32'(o_bus_write), 32'd1);
        check("s1_busy", 32'(o_busy), 32'd1);
        wait_idle("s1_idle", 100);
        check("s1_nwr", 32'(wr_val.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (i < wr_val.size()) check($sformatf("s1_val%0d", i), wr_val[i], exp_single[i]);
        for (int i = 0; i < 3; i++) if (i + 1 < wr_cyc.size()) check($sformatf("s1_gap%0d", i), 32'(wr_cyc[i+1] - wr_cyc[i]), 32'd5);
        check("s1_done", 32'(done_cnt), 32'd1);
        check("s1_pt_cnt", 32'(o_pt_cnt), 32'd4);

        // Overshoot clamps to end
        clear_log();
        start_sweep(2'd0, 32'd100, 32'd125, 32'd10, 16'd1);
        wait_idle("ov_idle", 100);
        check("ov_nwr", 32'(wr_val.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (i < wr_val.size()) check($sformatf("ov_val%0d", i), wr_val[i], exp_over[i]);
        check("ov_done", 32'(done_cnt), 32'd1);

        // TRI 0..20 step 10 dwell 0
        clear_log();
        start_sweep(2'd2, 32'd0, 32'd20, 32'd10, 16'd0);
        wait_writes("tri_wait", 7, 60);
        for (int i = 0; i < 7; i++) if (i < wr_val.size()) check($sformatf("tri_val%0d", i), wr_val[i], exp_tri[i]);
        for (int i = 0; i < 6; i++) if (i + 1 < wr_cyc.size()) check($sformatf("tri_gap%0d", i), 32'(wr_cyc[i+1] - wr_cyc[i]), 32'd2);
        check("tri_busy", 32'(o_busy), 32'd1);
        check("tri_done", 32'(done_cnt), 32'd0);
        abort_pulse();
        check("tri_abort_idle", 32'(o_busy), 32'd0);

        // Host contention during a sweeper write
        clear_log();
        start_sweep(2'd0, 32'd100, 32'd130, 32'd10, 16'd3);
        i_host_write = 1'b1; i_host_addrs = 32'd0; i_host_writedata = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("ct_stall%0d", i), 32'(o_stall), 32'd1);
            check($sformatf("ct_haddr%0d", i), o_bus_addrs, 32'd0);
            check($sformatf("ct_hdata%0d", i), o_bus_writedata, 32'd5);
            check($sformatf("ct_pt%0d", i), 32'(o_pt_cnt), 32'd0);
            @(posedge clk); #1;
        end
        i_host_write = 1'b0; i_host_writedata = '0;
        @(negedge clk);
        check("ct_nostall", 32'(o_stall), 32'd0);
        check("ct_grant_wr", 32'(o_bus_write), 32'd1);
        check("ct_grant_addr", o_bus_addrs, 32'd2);
        check("ct_grant_data", o_bus_writedata, 32'd100);
        @(posedge clk); #1;
        @(negedge clk);
        check("ct_dwell_wr", 32'(o_bus_write), 32'd0);
        check("ct_dwell_pt", 32'(o_pt_cnt), 32'd1);
        wait_idle("ct_idle", 100);
        check("ct_nwr", 32'(wr_val.size()), 32'd4);
        if (wr_cyc.size() >= 2) check("ct_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
        check("ct_done", 32'(done_cnt), 32'd1);

        // Abort mid-dwell of a LOOP sweep
        clear_log();
        start_sweep(2'd1, 32'd0, 32'd30, 32'd10, 16'd4);
        wait_writes("ab_wait", 2, 60);
        @(posedge clk); #1;
        abort_pulse();
        check("ab_idle", 32'(o_busy), 32'd0);
        check("ab_pt_hold", 32'(o_pt_cnt), 32'd2);
        check("ab_no_write", 32'(o_bus_write), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("ab_nwr", 32'(wr_val.size()), 32'd2);
        if (wr_val.size() >= 2) check("ab_val1", wr_val[1], 32'd10);
        check("ab_done", 32'(done_cnt), 32'd0);

        // Abort and start together in IDLE: abort wins
        @(posedge clk); #1;
        i_abort = 1'b1; i_start = 1'b1; i_mode = 2'd0;
        i_start_delta = 32'd1; i_end_delta = 32'd9; i_step_delta = 32'd1; i_dwell = 16'd0;
        @(posedge clk); #1;
        i_abort = 1'b0; i_start = 1'b0;
        check("abst_idle", 32'(o_busy), 32'd0);
        check("abst_pt", 32'(o_pt_cnt), 32'd2);

        // Reset during WRITE clears the strobe immediately
        start_sweep(2'd0, 32'd100, 32'd130, 32'd10, 16'd3);
        check("rw_pre", 32'(o_bus_write), 32'd1);
        #1 a_rst_n = 1'b0;
        #1;
        check("rw_bus_write", 32'(o_bus_write), 32'd0);
        check("rw_busy", 32'(o_busy), 32'd0);
        check("rw_pt", 32'(o_pt_cnt), 32'd0);
        #1 a_rst_n = 1'b1;

        // Degenerate: zero step
        clear_log();
        start_sweep(2'd1, 32'd50, 32'd100, 32'd0, 16'd2);
        wait_idle("dg0_idle", 50);
        check("dg0_nwr", 32'(wr_val.size()), 32'd1);
        if (wr_val.size() >= 1) check("dg0_val", wr_val[0], 32'd50);
        check("dg0_done", 32'(done_cnt), 32'd1);

        // Degenerate: start == end, with a start pulse while busy
        clear_log();
        start_sweep(2'd2, 32'd50, 32'd50, 32'd10, 16'd5);
        @(posedge clk); #1;
        i_start = 1'b1; i_mode = 2'd1; i_start_delta = 32'd77; i_end_delta = 32'd200; i_step_delta = 32'd1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_idle("dg1_idle", 50);
        check("dg1_nwr", 32'(wr_val.size()), 32'd1);
        if (wr_val.size() >= 1) check("dg1_val", wr_val[0], 32'd50);
        check("dg1_done", 32'(done_cnt), 32'd1);
        check("dg1_pt", 32'(o_pt_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
